stone_ram_arbiter: RTL and testbench
====================================

Name: stone_ram_arbiter

Overview:
- Sequences and shares the single-port 16x32 stone RAM between three requesters: the stone drawer (read-only) and the two rope controllers (read/write).
- Replaces the ad-hoc address/write-enable muxing inside the rope controllers.
- Provides fixed priority for the drawer, round-robin between the ropes, and a per-rope lock so a rope's read-modify-write of a stone is atomic with respect to the other rope.
- Sits between the rope controllers/drawer and the RAM macro.

Parameters:
- ADDR_W, 4, RAM address width (16 stone entries).
- DATA_W, 32, stone record width.
- READ_LAT, 1, RAM read latency in cycles (1 or 2 supported).
- LOCK_MAX, 200, max cycles a lock may be held before forced release (1..255).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- draw_req  in  1  drawer read request
- draw_addr  in  ADDR_W  drawer read address
- draw_gnt  out  1  drawer granted this cycle
- draw_rvalid  out  1  drawer read data valid on rdata
- r0_req, r1_req  in  1 each  rope access request
- r0_we, r1_we  in  1 each  1 = write, 0 = read
- r0_addr, r1_addr  in  ADDR_W each  rope address
- r0_wdata, r1_wdata  in  DATA_W each  rope write data
- r0_lock, r1_lock  in  1 each  request/hold exclusive rope access
- r0_gnt, r1_gnt  out  1 each  rope granted this cycle
- r0_rvalid, r1_rvalid  out  1 each  rope read data valid on rdata
- rdata  out  DATA_W  shared read data (registered copy of ram_q)
- ram_addr  out  ADDR_W  to RAM address
- ram_wdata  out  DATA_W  to RAM data
- ram_wren  out  1  to RAM write enable
- ram_q  in  DATA_W  from RAM q
- lock_owner  out  2  00 none, 01 rope0, 10 rope1
- lock_timeout  out  1  one-cycle pulse on forced lock release

Behaviour:
- Reset: all gnt/rvalid = 0; ram_wren = 0; ram_addr = 0; ram_wdata = 0; rdata = 0; lock_owner = 00; lock_timeout = 0; round-robin pointer = rope1 (so rope0 wins the first tie); lock counter = 0; read pipeline flushed. Reset mid-lock or mid-read drops the lock and suppresses any pending rvalid.
- Arbitration is combinational from the current inputs and registered state; at most one grant per cycle. ram_addr, ram_wdata and ram_wren are driven in the same cycle as the grant.
- Priority:
  1. draw_req always wins.
  2. Otherwise, the lock owner's request wins; the non-owner rope is never granted while a lock is held.
  3. Otherwise, if both ropes request, grant the rope other than the pointer; if one requests, grant it.
- The pointer updates to the granted rope on every rope grant.
- Write: granted rope with rK_we = 1 sets ram_wren = 1 and ram_wdata = rK_wdata. Draw grants never write. No rvalid for writes.
- Read: a granted read returns data READ_LAT cycles later. Requester-tagged shift register; rdata <= ram_q on the cycle the tag emerges, with the matching *_rvalid high for exactly that cycle. Back-to-back reads from mixed requesters are fully pipelined.
- Lock FSM states: UNLOCKED, LOCK0, LOCK1.
  - UNLOCKED -> LOCKk when rope k is granted with rK_lock = 1.
  - LOCKk -> UNLOCKED when rK_lock is sampled 0, or when the counter reaches LOCK_MAX. On the LOCK_MAX release, lock_timeout pulses 1 cycle.
  - The counter clears on lock entry and increments every locked cycle.
  - If the owner drops the lock in the same cycle the other rope requests, the other rope may be granted that same cycle.
- Drawer preemption inside a lock is allowed. The lock only excludes the other rope; the drawer only reads, and rope moves are one write.
- No request queueing: a requester holds req (with stable addr/we/wdata) until it sees gnt. Requests without gnt have no effect.
- Simultaneous lock requests in UNLOCKED: only the granted rope acquires the lock.

Test Plan:
- Reset then idle: all outputs 0, lock_owner = 00. Assert r0_req read addr 3 with RAM[3]=0x12345678 -> r0_gnt same cycle, r0_rvalid + rdata=0x12345678 exactly READ_LAT cycles later.
- draw_req, r0_req and r1_req all held 4 cycles -> draw_gnt every cycle, no rope grants. Drop draw_req -> grants alternate r0, r1, r0, r1.
- r0 read addr 5 with lock=1, then r0 write addr 5 data 0xABCD0003; r1_req held throughout -> r1_gnt stays 0 until r0_lock drops, then r1_gnt the next arbitration cycle. lock_owner reads 01 then 00.
- r1 acquires lock and holds r1_lock high with no further requests -> lock_timeout pulses after exactly LOCK_MAX locked cycles, lock_owner -> 00, and waiting r0 is granted.
- Pipelined reads draw@1, r0@2, r1@4 on consecutive cycles (READ_LAT=2) -> draw_rvalid, r0_rvalid, r1_rvalid on consecutive cycles with the correct data each.
- Reset asserted for 1 cycle while LOCK0 is held and a read is in flight -> no rvalid afterwards, lock_owner = 00, next tie grants rope0.

Source files
------------

// File: rtl/stone_ram_arbiter.sv
// rtl/stone_ram_arbiter.sv - arbiter sharing the single-port stone RAM between drawer and two ropes
//
// Purpose:
//   Grants one of three requesters per cycle onto the stone RAM. The drawer
//   (read-only) has fixed top priority. The two rope controllers share the
//   remaining slots round-robin, and either rope may take a lock that keeps
//   the other rope out while it performs a read-modify-write. Locks are
//   force-released after LOCK_MAX locked cycles.
//
// Ports:
//   clock, reset               system clock, synchronous active-high reset
//   draw_req/addr              drawer read request and address
//   draw_gnt, draw_rvalid      drawer granted this cycle / read data valid on rdata
//   rK_req/we/addr/wdata/lock  rope K access request (K = 0, 1)
//   rK_gnt, rK_rvalid          rope K granted this cycle / read data valid on rdata
//   rdata                      shared registered read data
//   ram_addr/wdata/wren, ram_q RAM macro interface
//   lock_owner                 00 none, 01 rope0, 10 rope1
//   lock_timeout               one-cycle pulse on forced lock release
//
// ram_q is expected READ_LAT-1 cycles after the address is presented
// (flow-through for READ_LAT=1); rdata registers it so that rdata and the
// matching rvalid appear exactly READ_LAT cycles after the grant.

module stone_ram_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1,
  parameter int LOCK_MAX = 200
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              draw_req,
  input  logic [ADDR_W-1:0] draw_addr,
  output logic              draw_gnt,
  output logic              draw_rvalid,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r0_lock,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic              r1_lock,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [1:0]        lock_owner,
  output logic              lock_timeout
);

  // State encoding doubles as the lock_owner code.
  typedef enum logic [1:0] {
    UNLOCKED = 2'b00,
    LOCK0    = 2'b01,
    LOCK1    = 2'b10
  } lock_state_t;

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_DRAW = 2'd1;
  localparam logic [1:0] TAG_R0   = 2'd2;
  localparam logic [1:0] TAG_R1   = 2'd3;

  localparam logic [7:0] CNT_LAST = 8'(LOCK_MAX - 1);

  lock_state_t state, state_next;
  logic [7:0]  lock_cnt, lock_cnt_next;
  logic        timeout_next;
  logic        ptr;            // last granted rope; 1 = rope1
  logic        ptr_next;
  logic        held0, held1;   // lock still asserted by its owner this cycle
  logic [1:0]  new_tag;

  // Read tag pipeline: tag_chain[1:0] is the tag issued this cycle,
  // tag_chain[2i+3:2i+2] is stage i+1 of the shift register.
  logic [2*READ_LAT-1:0] tag_sr;
  logic [2*READ_LAT+1:0] tag_chain;
  logic [1:0]            tag_out;
  logic                  load_data;

  assign lock_owner = state;

  // ---------------------------------------------------------------------
  // Arbitration and RAM drive
  // ---------------------------------------------------------------------
  always_comb begin
    draw_gnt  = 1'b0;
    r0_gnt    = 1'b0;
    r1_gnt    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wren  = 1'b0;
    new_tag   = TAG_NONE;
    ptr_next  = ptr;

    // An owner that drops its lock this cycle no longer excludes the other rope.
    held0 = (state == LOCK0) && r0_lock;
    held1 = (state == LOCK1) && r1_lock;

    if (!reset) begin
      if (draw_req) begin
        draw_gnt = 1'b1;
      end else if (held0) begin
        r0_gnt = r0_req;
      end else if (held1) begin
        r1_gnt = r1_req;
      end else if (r0_req && r1_req) begin
        r0_gnt = ptr;
        r1_gnt = !ptr;
      end else begin
        r0_gnt = r0_req;
        r1_gnt = r1_req;
      end
    end

    if (draw_gnt) begin
      ram_addr = draw_addr;
      new_tag  = TAG_DRAW;
    end else if (r0_gnt) begin
      ram_addr  = r0_addr;
      ram_wren  = r0_we;
      ram_wdata = r0_we ? r0_wdata : '0;
      new_tag   = r0_we ? TAG_NONE : TAG_R0;
      ptr_next  = 1'b0;
    end else if (r1_gnt) begin
      ram_addr  = r1_addr;
      ram_wren  = r1_we;
      ram_wdata = r1_we ? r1_wdata : '0;
      new_tag   = r1_we ? TAG_NONE : TAG_R1;
      ptr_next  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Lock FSM next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_next    = state;
    lock_cnt_next = lock_cnt;
    timeout_next  = 1'b0;

    if (held0 || held1) begin
      if (lock_cnt == CNT_LAST) begin
        state_next    = UNLOCKED;
        lock_cnt_next = '0;
        timeout_next  = 1'b1;
      end else begin
        lock_cnt_next = lock_cnt + 8'd1;
      end
    end else begin
      // Unlocked, or the owner released this cycle: a rope granted now with
      // its lock request asserted takes the lock.
      lock_cnt_next = '0;
      if (r0_gnt && r0_lock) begin
        state_next = LOCK0;
      end else if (r1_gnt && r1_lock) begin
        state_next = LOCK1;
      end else begin
        state_next = UNLOCKED;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= UNLOCKED;
      lock_cnt     <= '0;
      lock_timeout <= 1'b0;
      ptr          <= 1'b1;
    end else begin
      state        <= state_next;
      lock_cnt     <= lock_cnt_next;
      lock_timeout <= timeout_next;
      ptr          <= ptr_next;
    end
  end

  // ---------------------------------------------------------------------
  // Read return pipeline
  // ---------------------------------------------------------------------
  assign tag_chain = {tag_sr, new_tag};
  assign tag_out   = tag_sr[2*READ_LAT-1 -: 2];
  // Capture ram_q on the edge where a tag moves into the final stage.
  assign load_data = |tag_chain[2*READ_LAT-1 -: 2];

  always_ff @(posedge clock) begin
    if (reset) begin
      tag_sr <= '0;
      rdata  <= '0;
    end else begin
      tag_sr <= tag_chain[2*READ_LAT-1:0];
      if (load_data) begin
        rdata <= ram_q;
      end
    end
  end

  assign draw_rvalid = (tag_out == TAG_DRAW);
  assign r0_rvalid   = (tag_out == TAG_R0);
  assign r1_rvalid   = (tag_out == TAG_R1);

endmodule

// File: tb/tb_stone_ram_arbiter.sv
// tb/tb_stone_ram_arbiter.sv - scoreboard bench for stone_ram_arbiter

module tb_stone_ram_arbiter;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int RL = 2;
  localparam int LM = 200;

  logic          clock = 1'b0;
  logic          reset;
  logic          draw_req;
  logic [AW-1:0] draw_addr;
  logic          draw_gnt, draw_rvalid;
  logic          r0_req, r0_we, r0_lock, r0_gnt, r0_rvalid;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r1_req, r1_we, r1_lock, r1_gnt, r1_rvalid;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wren;
  logic [DW-1:0] ram_q;
  logic [1:0]    lock_owner;
  logic          lock_timeout;

  always #5 clock = ~clock;

  stone_ram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .LOCK_MAX(LM)
  ) dut (
    .clock(clock), .reset(reset),
    .draw_req(draw_req), .draw_addr(draw_addr), .draw_gnt(draw_gnt), .draw_rvalid(draw_rvalid),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_lock(r0_lock),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_lock(r1_lock),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
    .rdata(rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren),
    .ram_q(ram_q), .lock_owner(lock_owner), .lock_timeout(lock_timeout)
  );

  // RAM model: registered read (ram_q one cycle after the address, READ_LAT=2).
  logic          load_mem;
  logic [DW-1:0] mem [16];
  logic [DW-1:0] q_r;
  assign ram_q = q_r;

  always @(posedge clock) begin
    if (load_mem) begin
      for (int i = 0; i < 16; i++)
        mem[i] <= (i == 3) ? 32'h1234_5678 : (32'hC0DE_0000 | 32'(i));
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_wdata;
    end
    q_r <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // status vector: {draw_gnt, r0_gnt, r1_gnt, lock_owner[1:0], lock_timeout, ram_wren}
  typedef struct {
    string      nm;
    logic [6:0] v;
    bit         chk_rd;
  } st_t;

  typedef struct {
    logic [2:0]    who;   // {draw, r0, r1}
    logic [DW-1:0] d;
    int            due;
  } rd_t;

  st_t st_q[$];
  rd_t rd_q[$];
  int  n_vec = 0;
  int  n_bad = 0;
  bit  fin = 1'b0;
  bit  fin_done = 1'b0;

  // Monitor / scoreboard
  always @(negedge clock) begin
    st_t        se;
    rd_t        re;
    logic [6:0] act;
    logic [2:0] who;
    if (st_q.size() > 0) begin
      se  = st_q.pop_front();
      act = {draw_gnt, r0_gnt, r1_gnt, lock_owner, lock_timeout, ram_wren};
      n_vec++;
      if (act !== se.v) begin
        n_bad++;
        $display("FAIL status %s cyc %0d: got %b want %b", se.nm, cyc, act, se.v);
      end
      if (se.chk_rd) begin
        n_vec++;
        if (rdata !== '0) begin
          n_bad++;
          $display("FAIL rdata_zero %s cyc %0d: got %h want 0", se.nm, cyc, rdata);
        end
      end
    end
    who = {draw_rvalid, r0_rvalid, r1_rvalid};
    if (who != 3'b000) begin
      n_vec++;
      if (rd_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_rvalid cyc %0d: got who=%b rdata=%h want none", cyc, who, rdata);
      end else begin
        re = rd_q.pop_front();
        if (who !== re.who || rdata !== re.d || cyc != re.due) begin
          n_bad++;
          $display("FAIL read_resp cyc %0d: got who=%b data=%h want who=%b data=%h at cyc %0d",
                   cyc, who, rdata, re.who, re.d, re.due);
        end
      end
    end
    if (fin && !fin_done) begin
      n_vec++;
      if (rd_q.size() != 0 || st_q.size() != 0) begin
        n_bad++;
        $display("FAIL drain: got %0d reads %0d status pending want 0", rd_q.size(), st_q.size());
      end
      fin_done = 1'b1;
    end
  end

  task automatic tick(input string nm, input logic [6:0] v, input bit chk, input bit chk_rd);
    st_t e;
    if (chk) begin
      e.nm = nm; e.v = v; e.chk_rd = chk_rd;
      st_q.push_back(e);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic exp_rd(input logic [2:0] who, input logic [DW-1:0] d);
    rd_t e;
    e.who = who; e.d = d; e.due = cyc + RL;
    rd_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; load_mem = 1'b1;
    draw_req = 0; draw_addr = '0;
    r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0; r0_lock = 0;
    r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0; r1_lock = 0;
    @(posedge clock); #1;
    load_mem = 1'b0;
    tick("rst_hold", 7'b000_00_0_0, 1, 1);
    reset = 1'b0;
    tick("idle", 7'b000_00_0_0, 1, 1);

    // single rope0 read of addr 3
    r0_req = 1; r0_addr = 4'd3;
    exp_rd(3'b010, 32'h1234_5678);
    tick("t1_gnt", 7'b010_00_0_0, 1, 0);
    r0_req = 0;
    tick("t1_w1", 7'b000_00_0_0, 1, 0);
    tick("t1_w2", 7'b000_00_0_0, 1, 0);

    // drawer dominates, then ropes alternate (pointer = rope0 after t1)
    draw_req = 1; draw_addr = 4'd1;
    r0_req = 1; r0_addr = 4'd2;
    r1_req = 1; r1_addr = 4'd4;
    for (int i = 0; i < 4; i++) begin
      exp_rd(3'b100, 32'hC0DE_0001);
      tick("t2_draw", 7'b100_00_0_0, 1, 0);
    end
    draw_req = 0;
    exp_rd(3'b001, 32'hC0DE_0004); tick("t2_rr_a", 7'b001_00_0_0, 1, 0);
    exp_rd(3'b010, 32'hC0DE_0002); tick("t2_rr_b", 7'b010_00_0_0, 1, 0);
    exp_rd(3'b001, 32'hC0DE_0004); tick("t2_rr_c", 7'b001_00_0_0, 1, 0);
    r0_req = 0; r1_req = 0;
    tick("t2_idle", 7'b000_00_0_0, 1, 0);
    tick("t2_idle", 7'b000_00_0_0, 1, 0);

    // rope0 locked read-modify-write of addr 5 while rope1 waits
    r0_req = 1; r0_addr = 4'd5; r0_lock = 1;
    r1_req = 1; r1_addr = 4'd6;
    exp_rd(3'b010, 32'hC0DE_0005);
    tick("t3_lockgnt", 7'b010_00_0_0, 1, 0);
    r0_we = 1; r0_wdata = 32'hABCD_0003;
    tick("t3_write", 7'b010_01_0_1, 1, 0);
    r0_req = 0; r0_we = 0;
    tick("t3_hold", 7'b000_01_0_0, 1, 0);
    r0_lock = 0;
    exp_rd(3'b001, 32'hC0DE_0006);
    tick("t3_release", 7'b001_01_0_0, 1, 0);
    r1_req = 0;
    tick("t3_free", 7'b000_00_0_0, 1, 0);
    r0_req = 1; r0_addr = 4'd5;
    exp_rd(3'b010, 32'hABCD_0003);
    tick("t3_readback", 7'b010_00_0_0, 1, 0);
    r0_req = 0;
    tick("t3_idle", 7'b000_00_0_0, 1, 0);
    tick("t3_idle", 7'b000_00_0_0, 1, 0);

    // rope1 lock held with no traffic -> forced release after LM cycles
    r1_req = 1; r1_addr = 4'd7; r1_lock = 1;
    exp_rd(3'b001, 32'hC0DE_0007);
    tick("t4_acquire", 7'b001_00_0_0, 1, 0);
    r1_req = 0;
    r0_req = 1; r0_addr = 4'd8;
    for (int i = 0; i < LM; i++)
      tick("t4_locked", 7'b000_10_0_0, 1, 0);
    exp_rd(3'b010, 32'hC0DE_0008);
    tick("t4_timeout", 7'b010_00_1_0, 1, 0);
    r0_req = 0; r1_lock = 0;
    tick("t4_after", 7'b000_00_0_0, 1, 0);

    // back-to-back reads from mixed requesters
    draw_req = 1; draw_addr = 4'd1;
    exp_rd(3'b100, 32'hC0DE_0001);
    tick("t5_draw", 7'b100_00_0_0, 1, 0);
    draw_req = 0; r0_req = 1; r0_addr = 4'd2;
    exp_rd(3'b010, 32'hC0DE_0002);
    tick("t5_r0", 7'b010_00_0_0, 1, 0);
    r0_req = 0; r1_req = 1; r1_addr = 4'd4;
    exp_rd(3'b001, 32'hC0DE_0004);
    tick("t5_r1", 7'b001_00_0_0, 1, 0);
    r1_req = 0;
    for (int i = 0; i < 3; i++)
      tick("t5_idle", 7'b000_00_0_0, 1, 0);

    // reset during a lock with a read in flight
    r0_req = 1; r0_addr = 4'd9; r0_lock = 1;
    tick("t6_acquire", 7'b010_00_0_0, 1, 0);
    r0_req = 0; reset = 1;
    tick("t6_reset", 7'b000_01_0_0, 1, 0);
    reset = 0; r0_lock = 0;
    tick("t6_post", 7'b000_00_0_0, 1, 1);
    r0_req = 1; r0_addr = 4'd10;
    r1_req = 1; r1_addr = 4'd11;
    exp_rd(3'b010, 32'hC0DE_000A);
    tick("t6_tie", 7'b010_00_0_0, 1, 0);
    r0_req = 0; r1_req = 0;
    for (int i = 0; i < 3; i++)
      tick("t6_idle", 7'b000_00_0_0, 1, 0);

    fin = 1'b1;
    wait (fin_done);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
